// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter slice.
//   ARB_DATA_BITS : operand/result width of the shared ALU
//   ALU_LATENCY   : cycles from ALU operand capture to result
//   arb_state_e   : arbiter FSM encoding (IDLE = nothing in flight)
//   alu_op_t      : one ALU operation {a, b, sub}
package alu_arb_pkg;

  localparam int ARB_DATA_BITS = 8;
  localparam int ALU_LATENCY   = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [ARB_DATA_BITS-1:0] a;
    logic [ARB_DATA_BITS-1:0] b;
    logic                     sub;
  } alu_op_t;

endpackage

// File: rtl/alu.sv
// Registered adder/subtractor shared by the arbiter clients.
//   clk    : clock
//   reset  : synchronous, active-high
//   a, b   : operands
//   cin    : 1 = a-b (b inverted plus carry-in), 0 = a+b
//   result : registered sum/difference
//   cout   : registered carry out (subtract: 1 = no borrow)
//   zero   : registered result == 0
module alu #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] a,
  input  logic [DATA_BITS-1:0] b,
  input  logic                 cin,
  output logic [DATA_BITS-1:0] result,
  output logic                 cout,
  output logic                 zero
);

  logic [DATA_BITS:0] sum_s;

  // Two's-complement add; cin both inverts b and supplies the +1.
  always_comb begin
    sum_s = {1'b0, a} + {1'b0, b ^ {DATA_BITS{cin}}} + {{DATA_BITS{1'b0}}, cin};
  end

  // Result register: one cycle of latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      result <= '0;
      cout   <= 1'b0;
      zero   <= 1'b0;
    end else begin
      result <= sum_s[DATA_BITS-1:0];
      cout   <= sum_s[DATA_BITS];
      zero   <= (sum_s[DATA_BITS-1:0] == {DATA_BITS{1'b0}});
    end
  end

endmodule

// File: rtl/alu_arbiter_rr_picker.sv
// Combinational round-robin picker.
//   req       : request vector
//   ptr       : index that has highest priority this cycle
//   grant     : one-hot of the chosen requester (0 when none)
//   grant_idx : index of the chosen requester
//   any       : at least one request is set
module rr_picker #(
  parameter  int N        = 4,
  localparam int IDX_BITS = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]        req,
  input  logic [IDX_BITS-1:0] ptr,
  output logic [N-1:0]        grant,
  output logic [IDX_BITS-1:0] grant_idx,
  output logic                any
);

  logic [IDX_BITS-1:0] idx_s;
  logic [IDX_BITS-1:0] cand_idx_s;
  logic                found_s;
  int                  cand_s;

  // Walk ptr, ptr+1, ... (mod N); the first set request wins.
  always_comb begin
    idx_s      = '0;
    found_s    = 1'b0;
    cand_s     = 0;
    cand_idx_s = '0;
    for (int k = 0; k < N; k++) begin
      cand_s     = (int'(ptr) + k) % N;
      cand_idx_s = IDX_BITS'(cand_s);
      idx_s      = (!found_s && req[cand_idx_s]) ? cand_idx_s : idx_s;
      found_s    = found_s | req[cand_idx_s];
    end
  end

  // Expand the winning index into a one-hot grant.
  always_comb begin
    grant_idx = idx_s;
    any       = found_s;
    grant     = found_s ? ({{(N-1){1'b0}}, 1'b1} << idx_s) : {N{1'b0}};
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter in front of one registered add/sub ALU.
//   clk, reset                 : clock, synchronous active-low reset
//   req_valid/req_ready        : per-requester handshake (req_ready one-hot)
//   req_a/req_b/req_sub        : packed per-requester operands and op select
//   rsp_valid/rsp_ready        : single response channel
//   rsp_id/result/cout/zero    : response tag and ALU outputs passed through
//   alu_a/alu_b/alu_cin        : ALU operand drive
//   alu_result/alu_cout/zero   : ALU outputs
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter  int DATA_BITS = ARB_DATA_BITS,
  parameter  int NUM_REQ   = 4,
  localparam int ID_BITS   = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_a,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_b,
  input  logic [NUM_REQ-1:0]             req_sub,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [ID_BITS-1:0]             rsp_id,
  output logic [DATA_BITS-1:0]           rsp_result,
  output logic                           rsp_cout,
  output logic                           rsp_zero,
  output logic [DATA_BITS-1:0]           alu_a,
  output logic [DATA_BITS-1:0]           alu_b,
  output logic                           alu_cin,
  input  logic [DATA_BITS-1:0]           alu_result,
  input  logic                           alu_cout,
  input  logic                           alu_zero
);

  arb_state_e          state_r;
  arb_state_e          state_nxt_s;
  logic [ID_BITS-1:0]  rr_ptr_r;
  logic [ID_BITS-1:0]  held_id_r;
  alu_op_t             held_op_r;
  alu_op_t             grant_op_s;

  logic                inflight_s;
  logic                stall_s;
  logic                accept_s;
  logic [NUM_REQ-1:0]  pick_grant_s;
  logic [ID_BITS-1:0]  pick_idx_s;
  logic                pick_any_s;

  rr_picker #(
    .N (NUM_REQ)
  ) u_rr_picker (
    .req       (req_valid),
    .ptr       (rr_ptr_r),
    .grant     (pick_grant_s),
    .grant_idx (pick_idx_s),
    .any       (pick_any_s)
  );

  // Handshake qualifiers; a pending response that is not taken blocks new grants
  // so the ALU result stays stable.
  always_comb begin
    inflight_s = (state_r == ST_BUSY);
    stall_s    = inflight_s & ~rsp_ready;
    accept_s   = reset & ~stall_s & pick_any_s;
    grant_op_s.a   = req_a[pick_idx_s*DATA_BITS +: DATA_BITS];
    grant_op_s.b   = req_b[pick_idx_s*DATA_BITS +: DATA_BITS];
    grant_op_s.sub = req_sub[pick_idx_s];
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: an accept always leaves an op in flight; BUSY only drains when
  // the response is taken and nothing new is accepted.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_BUSY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (stall_s || accept_s) begin
          state_nxt_s = ST_BUSY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: grant, response channel and ALU operand mux. Outside the accept
  // cycle the ALU re-computes the held op, keeping its output constant.
  always_comb begin
    req_ready  = {NUM_REQ{1'b0}};
    rsp_valid  = 1'b0;
    alu_a      = {DATA_BITS{1'b0}};
    alu_b      = {DATA_BITS{1'b0}};
    alu_cin    = 1'b0;
    rsp_id     = held_id_r;
    rsp_result = alu_result;
    rsp_cout   = alu_cout;
    rsp_zero   = alu_zero;
    if (!reset) begin
      req_ready = {NUM_REQ{1'b0}};
      rsp_valid = 1'b0;
    end else if (accept_s) begin
      req_ready = pick_grant_s;
      rsp_valid = inflight_s;
      alu_a     = grant_op_s.a;
      alu_b     = grant_op_s.b;
      alu_cin   = grant_op_s.sub;
    end else begin
      req_ready = {NUM_REQ{1'b0}};
      rsp_valid = inflight_s;
      alu_a     = held_op_r.a;
      alu_b     = held_op_r.b;
      alu_cin   = held_op_r.sub;
    end
  end

  // Held op and round-robin pointer; both only move on an accept.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr_r  <= '0;
      held_id_r <= '0;
      held_op_r <= '0;
    end else if (accept_s) begin
      rr_ptr_r  <= (pick_idx_s == ID_BITS'(NUM_REQ-1)) ? '0 : pick_idx_s + 1'b1;
      held_id_r <= pick_idx_s;
      held_op_r <= grant_op_s;
    end else begin
      rr_ptr_r  <= rr_ptr_r;
      held_id_r <= held_id_r;
      held_op_r <= held_op_r;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter driving the shared alu. Expected responses are
// queued as each op is issued; a monitor pops and compares on every response handshake.
module tb_alu_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_sub;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_result;
  logic        rsp_cout;
  logic        rsp_zero;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_cin;
  logic [7:0]  alu_result;
  logic        alu_cout;
  logic        alu_zero;
  logic        alu_rst;

  typedef struct {
    logic [1:0] id;
    logic [7:0] result;
    logic       cout;
    logic       zero;
  } exp_rsp_t;

  exp_rsp_t sb[$];
  int vec_cnt  = 0;
  int miscomp  = 0;

  assign alu_rst = ~reset;

  alu_arbiter #(.DATA_BITS(8), .NUM_REQ(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_cout(rsp_cout), .rsp_zero(rsp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_cout(alu_cout), .alu_zero(alu_zero)
  );

  alu #(.DATA_BITS(8)) u_alu (
    .clk(clk), .reset(alu_rst),
    .a(alu_a), .b(alu_b), .cin(alu_cin),
    .result(alu_result), .cout(alu_cout), .zero(alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscomp++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b, input logic sub);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
    req_sub[i]      = sub;
  endtask

  task automatic push(input logic [1:0] id, input logic [7:0] res, input logic c, input logic z);
    exp_rsp_t e;
    e.id = id; e.result = res; e.cout = c; e.zero = z;
    sb.push_back(e);
  endtask

  // One clock cycle: entered at posedge+1, drives valids, checks the grant, leaves at next posedge+1.
  task automatic cycle(input logic [3:0] vmask, input logic [3:0] exp_ready, input string nm);
    req_valid = vmask;
    #1;
    chk(nm, 32'(req_ready), 32'(exp_ready));
    @(posedge clk);
    #1;
  endtask

  // Response monitor.
  always @(negedge clk) begin
    exp_rsp_t e;
    if (reset && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        vec_cnt++;
        miscomp++;
        $display("FAIL unexpected_rsp: got id %0d result 0x%0h, expected no response", rsp_id, rsp_result);
      end else begin
        e = sb.pop_front();
        chk("rsp_id",     32'(rsp_id),     32'(e.id));
        chk("rsp_result", 32'(rsp_result), 32'(e.result));
        chk("rsp_cout",   32'(rsp_cout),   32'(e.cout));
        chk("rsp_zero",   32'(rsp_zero),   32'(e.zero));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    req_a     = 32'h0;
    req_b     = 32'h0;
    req_sub   = 4'h0;
    set_op(0, 8'h10, 8'h01, 1'b0);
    set_op(1, 8'h20, 8'h08, 1'b1);
    set_op(2, 8'h80, 8'h80, 1'b0);
    set_op(3, 8'h03, 8'h05, 1'b1);

    // Reset state, with every request valid to show grants are held off.
    @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_alu_a",     32'(alu_a),     32'h0);
    chk("rst_alu_b",     32'(alu_b),     32'h0);
    chk("rst_alu_cin",   32'(alu_cin),   32'h0);
    reset     = 1'b1;
    req_valid = 4'h0;
    @(posedge clk);
    #1;

    // 1: single add from req0, one-cycle latency.
    set_op(0, 8'h05, 8'h03, 1'b0);
    push(2'd0, 8'h08, 1'b0, 1'b0);
    cycle(4'b0001, 4'b0001, "t1_grant");
    chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    cycle(4'b0000, 4'b0000, "t1_idle");
    chk("t1_drained", 32'(rsp_valid), 32'h0);

    // 2: equal-operand subtract, then 0xFF+0x01 wrap, then 3-5 borrow; back to back.
    set_op(2, 8'h05, 8'h05, 1'b1);
    push(2'd2, 8'h00, 1'b1, 1'b1);
    cycle(4'b0100, 4'b0100, "t2_grant2");
    set_op(1, 8'hFF, 8'h01, 1'b0);
    push(2'd1, 8'h00, 1'b1, 1'b1);
    cycle(4'b0010, 4'b0010, "t2_grant1");
    push(2'd3, 8'hFE, 1'b0, 1'b0);
    cycle(4'b1000, 4'b1000, "t2_grant3");
    cycle(4'b0000, 4'b0000, "t2_idle_a");
    cycle(4'b0000, 4'b0000, "t2_idle_b");

    // 3: all valid, rr_ptr back at 0 -> 0,1,2,3,0.
    set_op(0, 8'h10, 8'h01, 1'b0);
    set_op(1, 8'h20, 8'h08, 1'b1);
    set_op(2, 8'h80, 8'h80, 1'b0);
    push(2'd0, 8'h11, 1'b0, 1'b0);
    push(2'd1, 8'h18, 1'b1, 1'b0);
    push(2'd2, 8'h00, 1'b1, 1'b1);
    push(2'd3, 8'hFE, 1'b0, 1'b0);
    push(2'd0, 8'h11, 1'b0, 1'b0);
    cycle(4'b1111, 4'b0001, "t3_grant_a");
    cycle(4'b1111, 4'b0010, "t3_grant_b");
    cycle(4'b1111, 4'b0100, "t3_grant_c");
    cycle(4'b1111, 4'b1000, "t3_grant_d");
    cycle(4'b1111, 4'b0001, "t3_grant_e");
    cycle(4'b0000, 4'b0000, "t3_idle_a");
    cycle(4'b0000, 4'b0000, "t3_idle_b");

    // 4: response back-pressure for 3 cycles with req1/req3 waiting (rr_ptr=1).
    push(2'd1, 8'h18, 1'b1, 1'b0);
    cycle(4'b1010, 4'b0010, "t4_grant1");
    rsp_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      req_valid = 4'b1010;
      #1;
      chk("t4_stall_ready",  32'(req_ready),  32'h0);
      chk("t4_stall_valid",  32'(rsp_valid),  32'h1);
      chk("t4_stall_id",     32'(rsp_id),     32'h1);
      chk("t4_stall_result", 32'(rsp_result), 32'h18);
      chk("t4_stall_cout",   32'(rsp_cout),   32'h1);
      chk("t4_stall_alu_a",  32'(alu_a),      32'h20);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    push(2'd3, 8'hFE, 1'b0, 1'b0);
    cycle(4'b1010, 4'b1000, "t4_release3");
    push(2'd1, 8'h18, 1'b1, 1'b0);
    cycle(4'b0010, 4'b0010, "t4_then1");
    cycle(4'b0000, 4'b0000, "t4_idle_a");
    cycle(4'b0000, 4'b0000, "t4_idle_b");

    // 5: reset while an op is in flight; it must vanish and rr_ptr return to 0.
    cycle(4'b0001, 4'b0001, "t5_grant0");
    reset     = 1'b0;
    req_valid = 4'b0000;
    #1;
    chk("t5_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("t5_rst_req_ready", 32'(req_ready), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("t5_post_rst_valid", 32'(rsp_valid), 32'h0);
    push(2'd0, 8'h11, 1'b0, 1'b0);
    cycle(4'b1111, 4'b0001, "t5_first_grant");
    cycle(4'b0000, 4'b0000, "t5_idle_a");
    cycle(4'b0000, 4'b0000, "t5_idle_b");

    // 6: move rr_ptr to 3, then req3/req0 only -> 3, 0 (wrap), 3.
    push(2'd2, 8'h00, 1'b1, 1'b1);
    cycle(4'b0100, 4'b0100, "t6_grant2");
    cycle(4'b0000, 4'b0000, "t6_idle");
    push(2'd3, 8'hFE, 1'b0, 1'b0);
    cycle(4'b1001, 4'b1000, "t6_grant3");
    push(2'd0, 8'h11, 1'b0, 1'b0);
    cycle(4'b1001, 4'b0001, "t6_wrap0");
    push(2'd3, 8'hFE, 1'b0, 1'b0);
    cycle(4'b1001, 4'b1000, "t6_grant3b");
    cycle(4'b0000, 4'b0000, "t6_idle_a");
    cycle(4'b0000, 4'b0000, "t6_idle_b");

    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscomp);
    $finish;
  end

endmodule
